// File: rtl/oled_cmd_pkg.sv
// -----------------------------------------------------------------------------
// oled_cmd_pkg
// Shared constants for the SSD1331 (OLEDrgb) bar command streamer:
//   - command opcodes and command lengths in bytes
//   - level thresholds and RGB565 colours used for bar colouring
//   - streamer FSM state type
// -----------------------------------------------------------------------------
package oled_cmd_pkg;

  localparam logic [7:0] OLED_DRAW_RECT = 8'h22;
  localparam logic [7:0] OLED_CLEAR_WIN = 8'h25;

  localparam int DRAW_LEN  = 11;
  localparam int CLEAR_LEN = 5;

  // Colour bands: level below the threshold selects the colour
  localparam logic [7:0] LVL_TH_RED    = 8'd16;
  localparam logic [7:0] LVL_TH_ORANGE = 8'd32;
  localparam logic [7:0] LVL_TH_YELLOW = 8'd48;
  localparam logic [7:0] LVL_TH_LIME   = 8'd72;

  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_ORANGE = 16'hFC00;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_LIME   = 16'h87E0;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW,
    ST_CLEAR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rect_color_lut.sv
// -----------------------------------------------------------------------------
// rect_color_lut
// Maps a bar level to the three SSD1331 colour channel bytes (combinational).
// Ports:
//   lvl    [7:0] in  clamped bar level (end column)
//   chan_a [7:0] out {2'b00, R5, 1'b0}
//   chan_b [7:0] out {2'b00, G6}
//   chan_c [7:0] out {2'b00, B5, 1'b0}
// -----------------------------------------------------------------------------
module rect_color_lut
  import oled_cmd_pkg::*;
(
  input  logic [7:0] lvl,
  output logic [7:0] chan_a,
  output logic [7:0] chan_b,
  output logic [7:0] chan_c
);

  logic [15:0] rgb;

  always_comb begin
    if (lvl < LVL_TH_RED)         rgb = RGB_RED;
    else if (lvl < LVL_TH_ORANGE) rgb = RGB_ORANGE;
    else if (lvl < LVL_TH_YELLOW) rgb = RGB_YELLOW;
    else if (lvl < LVL_TH_LIME)   rgb = RGB_LIME;
    else                          rgb = RGB_GREEN;
  end

  assign chan_a = {2'b00, rgb[15:11], 1'b0};
  assign chan_b = {2'b00, rgb[10:5]};
  assign chan_c = {2'b00, rgb[4:0], 1'b0};

endmodule

// File: rtl/rect_bar_cmd_streamer.sv
// -----------------------------------------------------------------------------
// rect_bar_cmd_streamer
// Streams SSD1331 command bytes drawing NUM_BARS horizontal level bars: per bar
// one Draw Rectangle (0x22, 11 bytes) plus an optional Clear Window (0x25,
// 5 bytes) covering the unused tail of the row band.
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous active-low reset
//   start      in   frame request, honoured only while idle
//   level      in   8 bits per bar (bar i at [8i+7:8i]), sampled with start
//   cmd_byte   out  command byte presented downstream
//   cmd_valid  out  cmd_byte valid
//   cmd_ready  in   downstream accepts the byte
//   cmd_last   out  final byte of the frame
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module rect_bar_cmd_streamer
  import oled_cmd_pkg::*;
#(
  parameter int NUM_BARS   = 4,
  parameter int COL_START  = 0,
  parameter int COL_MAX    = 95,
  parameter int ROW_START  = 16,
  parameter int BAR_HEIGHT = 16,
  parameter int ROW_GAP    = 0,
  parameter int CLEAR_TAIL = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [8*NUM_BARS-1:0]   level,
  output logic [7:0]              cmd_byte,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_last,
  output logic                    busy,
  output logic                    done
);

  localparam int BW       = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int LAST_ROW = ROW_START + (NUM_BARS - 1) * (BAR_HEIGHT + ROW_GAP) + BAR_HEIGHT - 1;
  localparam logic [7:0] COL_START_B = 8'(COL_START);
  localparam logic [7:0] COL_MAX_B   = 8'(COL_MAX);

  if (NUM_BARS < 1 || BAR_HEIGHT < 1 || LAST_ROW > 63 || COL_START > COL_MAX || COL_MAX > 255)
  begin : g_param_check
    $fatal(1, "rect_bar_cmd_streamer: bar geometry does not fit the display");
  end

  function automatic logic is_empty(input logic [7:0] l);
    return (l == 8'd0) || (int'(l) < COL_START);
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      lvl_q [NUM_BARS];
  logic [7:0]      lvl_d [NUM_BARS];
  logic [BW-1:0]   bar_q, bar_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [7:0]      cur_lvl, row_s, row_e, clr_c1, draw_byte, clear_byte;
  logic [7:0]      chan_a, chan_b, chan_c;
  logic            cur_empty, draw_has_clear;
  logic [NUM_BARS-1:0] emit;
  int unsigned     from_idx;
  logic            nxt_found;
  logic [BW-1:0]   nxt_bar;
  state_e          adv_state;

  assign cur_lvl        = lvl_q[bar_q];
  assign cur_empty      = is_empty(cur_lvl);
  assign draw_has_clear = (CLEAR_TAIL != 0) && (int'(cur_lvl) < COL_MAX);
  assign row_s          = 8'(ROW_START + int'(bar_q) * (BAR_HEIGHT + ROW_GAP));
  assign row_e          = row_s + 8'(BAR_HEIGHT - 1);
  assign clr_c1         = cur_empty ? COL_START_B : cur_lvl + 8'd1;

  rect_color_lut u_lut (
    .lvl    (cur_lvl),
    .chan_a (chan_a),
    .chan_b (chan_b),
    .chan_c (chan_c)
  );

  // The NEXT step is folded into the last-byte transition: the next bar that
  // emits anything is found combinationally, so bars skipped entirely never
  // cost a cycle and the stream has no bubbles between bars.
  always_comb begin
    emit = '0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      emit[BW'(i)] = !is_empty(lvl_q[BW'(i)]) || (CLEAR_TAIL != 0);
    end
  end

  always_comb begin
    from_idx  = (state_q == ST_LOAD) ? 32'd0 : 32'(bar_q) + 32'd1;
    nxt_found = 1'b0;
    nxt_bar   = '0;
    for (int unsigned i = 0; i < NUM_BARS; i++) begin
      if (!nxt_found && i >= from_idx && emit[BW'(i)]) begin
        nxt_found = 1'b1;
        nxt_bar   = BW'(i);
      end
    end
    if (!nxt_found)                   adv_state = ST_DONE;
    else if (is_empty(lvl_q[nxt_bar])) adv_state = ST_CLEAR;
    else                              adv_state = ST_DRAW;
  end

  always_comb begin
    case (cnt_q)
      4'd0:        draw_byte = OLED_DRAW_RECT;
      4'd1:        draw_byte = COL_START_B;
      4'd2:        draw_byte = row_s;
      4'd3:        draw_byte = cur_lvl;
      4'd4:        draw_byte = row_e;
      4'd5, 4'd8:  draw_byte = chan_c;
      4'd6, 4'd9:  draw_byte = chan_b;
      4'd7, 4'd10: draw_byte = chan_a;
      default:     draw_byte = '0;
    endcase
    case (cnt_q)
      4'd0:    clear_byte = OLED_CLEAR_WIN;
      4'd1:    clear_byte = clr_c1;
      4'd2:    clear_byte = row_s;
      4'd3:    clear_byte = COL_MAX_B;
      4'd4:    clear_byte = row_e;
      default: clear_byte = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bar_d     = bar_q;
    cnt_d     = cnt_q;
    lvl_d     = lvl_q;
    cmd_byte  = '0;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < NUM_BARS; i++) begin
            lvl_d[BW'(i)] = (level[8*i +: 8] > COL_MAX_B) ? COL_MAX_B : level[8*i +: 8];
          end
          bar_d   = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        bar_d   = nxt_bar;
        cnt_d   = '0;
        state_d = adv_state;
      end
      ST_DRAW: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_byte  = draw_byte;
        cmd_last  = (cnt_q == 4'(DRAW_LEN - 1)) && !draw_has_clear && !nxt_found;
        if (cmd_ready) begin
          if (cnt_q == 4'(DRAW_LEN - 1)) begin
            cnt_d = '0;
            if (draw_has_clear) begin
              state_d = ST_CLEAR;
            end else begin
              bar_d   = nxt_bar;
              state_d = adv_state;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_byte  = clear_byte;
        cmd_last  = (cnt_q == 4'(CLEAR_LEN - 1)) && !nxt_found;
        if (cmd_ready) begin
          if (cnt_q == 4'(CLEAR_LEN - 1)) begin
            cnt_d   = '0;
            bar_d   = nxt_bar;
            state_d = adv_state;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      bar_q   <= '0;
      cnt_q   <= '0;
      lvl_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      bar_q   <= bar_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

endmodule

// File: doc/rect_bar_cmd_streamer.md
Name: rect_bar_cmd_streamer

Overview:
- Generates OLEDrgb (SSD1331) command bytes for a stack of NUM_BARS horizontal level bars. Each bar is one Draw Rectangle (0x22) command plus an optional Clear Window (0x25) command for the unused tail.
- Bytes are streamed one per valid/ready handshake to the SPI byte sender.
- Sits between the AXI register bank (bar levels, start strobe) and the SPI/OLED controller, and replaces the fixed single-bar combinational command builder.

Parameters:
- NUM_BARS, 4, number of bars; bar i occupies rows ROW_START+i*(BAR_HEIGHT+ROW_GAP) .. +BAR_HEIGHT-1.
- COL_START, 0, first column of every bar.
- COL_MAX, 95, last display column; levels are clamped to this value.
- ROW_START, 16, top row of bar 0.
- BAR_HEIGHT, 16, rows per bar (≥1).
- ROW_GAP, 0, blank rows between bars.
- CLEAR_TAIL, 1, 1 = emit a 0x25 clear for columns level+1..COL_MAX after each bar.
- Elaboration check: the last bar's end row must be ≤63 and COL_START ≤ COL_MAX; otherwise $fatal.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to stream a frame; honoured only when busy=0.
- level  in  8*NUM_BARS  end column per bar; bar i is in bits [8i+7:8i]. Sampled on the start cycle only.
- cmd_byte  out  8  current command byte.
- cmd_valid  out  1  cmd_byte is valid.
- cmd_ready  in  1  downstream accepts the byte.
- cmd_last  out  1  qualifies the final byte of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; cmd_byte=0, cmd_valid=0, cmd_last=0, busy=0, done=0; latched levels cleared.
  - Reset mid-frame aborts immediately and no further bytes are emitted.
- Transfer rule: a byte transfers when cmd_valid & cmd_ready at a rising edge.
  - cmd_byte, cmd_valid and cmd_last must hold stable while cmd_valid=1 & cmd_ready=0.
  - No bubbles between bytes while cmd_ready=1 (one byte per cycle).
- States:
  - IDLE: on start=1, latch the clamped levels (lvl = min(level, COL_MAX)), set busy=1, go to LOAD. start while busy=1 is ignored, not queued.
  - LOAD (1 cycle): compute colour and rows for bar index b=0 and present the first byte. cmd_valid rises on the edge after LOAD, i.e. the 2nd edge after start is sampled.
  - DRAW: emit 11 bytes 0x22, COL_START, rs, lvl, re, C, B, A, C, B, A.
    - Skipped entirely when lvl < COL_START (level 0 with COL_START=0 counts as empty only when level==0; a level-0 bar is empty).
    - After byte 10: go to CLEAR if CLEAR_TAIL=1 and lvl < COL_MAX, else NEXT.
  - CLEAR: emit 5 bytes 0x25, c1, rs, COL_MAX, re.
    - c1 = lvl+1, or COL_START for an empty bar.
  - NEXT: b++; if b==NUM_BARS go to DONE, else recompute and go to DRAW/CLEAR with zero idle cycles.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Colour from lvl, as RGB565:
  - <16: F800
  - <32: FC00
  - <48: FFE0
  - <72: 87E0
  - otherwise: 07E0
- Channel bytes:
  - A = {2'b00, R5, 1'b0}
  - B = {2'b00, G6}
  - C = {2'b00, B5, 1'b0}
- Rows: rs/re are computed as unsigned 8-bit values; parameters guarantee no overflow.
- cmd_last is asserted only with the final byte of the final emitted command of bar NUM_BARS-1.

Decomposition:
- Package oled_cmd_pkg holds:
  - opcodes OLED_DRAW_RECT=8'h22 and OLED_CLEAR_WIN=8'h25;
  - draw length 11 and clear length 5;
  - colour thresholds and RGB565 constants;
  - state enum typedef.
- Sub-module rect_color_lut (lvl[7:0] → chan_a, chan_b, chan_c), purely combinational.
- Byte mux, byte counter and FSM stay in the top module.

Test Plan:
- NUM_BARS=2, ROW_START=16, BAR_HEIGHT=16, ROW_GAP=0, CLEAR_TAIL=1, level={8'd40, 8'd10}, start, cmd_ready=1 → 32 bytes:
  - 22 00 10 0A 1F 00 00 3E 00 00 3E, then 25 0B 10 5F 1F;
  - 22 00 20 28 2F 00 3F 3E 00 3F 3E, then 25 29 20 5F 2F;
  - cmd_last only on the final 2F; done pulses the next cycle.
- Clamp and empty (same config), level={8'd200, 8'd0} → bar0 only 25 00 10 5F 1F; bar1 22 00 20 5F 2F 00 3F 00 00 3F 00 with no clear; 16 bytes total.
- Backpressure: drop cmd_ready for 3 cycles while the byte at index 3 (0x0A) is presented → 0x0A and cmd_valid held stable; stream resumes with no loss or duplication.
- Start pulsed again while busy=1 and during DONE → ignored; exactly one frame is produced, and level changes mid-frame have no effect.
- resetn=0 for one edge during bar1 DRAW → next cycle cmd_valid=0, busy=0, state IDLE; a new start then produces a full correct frame.
- Colour thresholds: single bar with levels 15/16/31/32/47/48/71/72 → A,B,C bytes:
  - 15 → 3E,00,00; 16 → 3E,20,00
  - 31 → 3E,20,00; 32 → 3E,3F,00
  - 47 → 3E,3F,00; 48 → 20,3F,00
  - 71 → 20,3F,00; 72 → 00,3F,00
